// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_CH clients,
// with packet locking via req_last. Optional watchdog: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     req_valid,
    input  logic [8*NUM_CH-1:0]   req_data,
    input  logic [NUM_CH-1:0]     req_last,
    output logic [NUM_CH-1:0]     req_ready,
    input  logic [2:0]            baud_sel,
    output logic                  tx_send_en,
    output logic [7:0]            tx_data,
    input  logic                  tx_done,
    output logic [2:0]            baud_set,
    output logic                  busy,
    output logic [2:0]            grant_id,
    output logic [15:0]           byte_count,
    output logic                  timeout_err
);

    localparam int DATA_W = 8;

    if (NUM_CH < 2 || NUM_CH > 8 || GAP_CYCLES < 1 || GAP_CYCLES > 255 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [2:0]          rr_ptr, rr_ptr_nxt;
    logic                lock, lock_nxt;
    logic [7:0]          gap_cnt, gap_cnt_nxt;
    logic [NUM_CH-1:0]   req_ready_nxt;
    logic                tx_send_en_nxt;
    logic [DATA_W-1:0]   tx_data_nxt;
    logic [2:0]          baud_set_nxt;
    logic [2:0]          grant_id_nxt;
    logic [15:0]         byte_count_nxt;
    logic                busy_nxt;

    // Channel views padded to eight entries so a 3-bit index is always in range.
    logic [7:0]          valid_pad;
    logic [7:0]          last_pad;
    logic [DATA_W-1:0]   data_arr [8];

    assign valid_pad = 8'(req_valid);
    assign last_pad  = 8'(req_last);

    for (genvar k = 0; k < 8; k++) begin : g_data
        if (k < NUM_CH) begin : g_used
            assign data_arr[k] = req_data[8*k +: 8];
        end else begin : g_pad
            assign data_arr[k] = '0;
        end
    end

    function automatic logic [2:0] next_ch(input logic [2:0] c);
        return (c == 3'(NUM_CH - 1)) ? 3'd0 : c + 3'd1;
    endfunction

    logic       grant_vld;
    logic [2:0] grant_idx;
    logic [3:0] cand_sum;

    // Descending search so the channel closest to rr_ptr is the last to win.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 3'd0;
        cand_sum  = 4'd0;
        if (lock) begin
            grant_vld = valid_pad[grant_id];
            grant_idx = grant_id;
        end else begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                cand_sum = {1'b0, rr_ptr} + 4'(k);
                if (cand_sum >= 4'(NUM_CH)) begin
                    cand_sum = cand_sum - 4'(NUM_CH);
                end
                if (valid_pad[cand_sum[2:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand_sum[2:0];
                end
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0] to_cnt, to_cnt_nxt;
    logic        timeout_err_nxt;
`endif

    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        lock_nxt       = lock;
        gap_cnt_nxt    = gap_cnt;
        req_ready_nxt  = '0;
        tx_send_en_nxt = tx_send_en;
        tx_data_nxt    = tx_data;
        baud_set_nxt   = baud_set;
        grant_id_nxt   = grant_id;
        byte_count_nxt = byte_count;
`ifdef UART_ARB_TIMEOUT_EN
        to_cnt_nxt      = to_cnt;
        timeout_err_nxt = timeout_err;
`endif
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    req_ready_nxt  = {{(NUM_CH-1){1'b0}}, 1'b1} << grant_idx;
                    tx_data_nxt    = data_arr[grant_idx];
                    baud_set_nxt   = baud_sel;
                    grant_id_nxt   = grant_idx;
                    tx_send_en_nxt = 1'b1;
                    lock_nxt       = ~last_pad[grant_idx];
                    if (last_pad[grant_idx]) begin
                        rr_ptr_nxt = next_ch(grant_idx);
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    to_cnt_nxt = '0;
`endif
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (tx_done) begin
                    tx_send_en_nxt = 1'b0;
                    byte_count_nxt = byte_count + 16'd1;
                    gap_cnt_nxt    = 8'(GAP_CYCLES);
                    state_nxt      = GAP;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    // Abandon the stalled byte and let the next channel in.
                    timeout_err_nxt = 1'b1;
                    tx_send_en_nxt  = 1'b0;
                    lock_nxt        = 1'b0;
                    rr_ptr_nxt      = next_ch(grant_id);
                    gap_cnt_nxt     = 8'(GAP_CYCLES);
                    state_nxt       = GAP;
                end else begin
                    to_cnt_nxt = to_cnt + 32'd1;
                end
`endif
            end
            GAP: begin
                if (gap_cnt <= 8'd1) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 8'd1;
                end
            end
            default: begin
                state_nxt      = IDLE;
                tx_send_en_nxt = 1'b0;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= 3'd0;
            lock       <= 1'b0;
            gap_cnt    <= 8'd0;
            req_ready  <= '0;
            tx_send_en <= 1'b0;
            tx_data    <= '0;
            baud_set   <= 3'd0;
            grant_id   <= 3'd0;
            byte_count <= 16'd0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            lock       <= lock_nxt;
            gap_cnt    <= gap_cnt_nxt;
            req_ready  <= req_ready_nxt;
            tx_send_en <= tx_send_en_nxt;
            tx_data    <= tx_data_nxt;
            baud_set   <= baud_set_nxt;
            grant_id   <= grant_id_nxt;
            byte_count <= byte_count_nxt;
            busy       <= busy_nxt;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            to_cnt      <= to_cnt_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: client queues feed the arbiter, a scoreboard
// holds the expected byte order, and a simple transmitter model returns tx_done.
module tb_uart_tx_arbiter;

    localparam int NUM_CH = 4;
    localparam int BYTE_T = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NUM_CH-1:0]   req_valid;
    logic [8*NUM_CH-1:0] req_data;
    logic [NUM_CH-1:0]   req_last;
    logic [NUM_CH-1:0]   req_ready;
    logic [2:0]          baud_sel = 3'd0;
    logic                tx_send_en;
    logic [7:0]          tx_data;
    logic                tx_done = 1'b0;
    logic [2:0]          baud_set;
    logic                busy;
    logic [2:0]          grant_id;
    logic [15:0]         byte_count;
    logic                timeout_err;

    uart_tx_arbiter #(.NUM_CH(NUM_CH), .GAP_CYCLES(2), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .baud_sel(baud_sel),
        .tx_send_en(tx_send_en), .tx_data(tx_data), .tx_done(tx_done),
        .baud_set(baud_set), .busy(busy), .grant_id(grant_id),
        .byte_count(byte_count), .timeout_err(timeout_err)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Client model: per-channel byte memories {last, data} presented in order.
    logic [8:0]        ch_mem [NUM_CH][16];
    int                ch_wr [NUM_CH];
    int                ch_rd [NUM_CH];
    logic [NUM_CH-1:0] acc = '0;

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_wr[i] = 0;
            ch_rd[i] = 0;
        end
    end

    always_comb begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_rd[i] < ch_wr[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = ch_mem[i][ch_rd[i]][7:0];
                req_last[i]        = ch_mem[i][ch_rd[i]][8];
            end
        end
    end

    always @(negedge clk) acc = req_ready & req_valid;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (acc[i]) ch_rd[i] = ch_rd[i] + 1;
        end
        acc = '0;
    end

    // Transmitter model: tx_done pulse BYTE_T cycles into each byte.
    logic tx_model_en = 1'b1;
    int   tx_cnt = 0;
    always @(posedge clk) begin
        #1;
        tx_done = 1'b0;
        if (tx_send_en && tx_model_en) begin
            tx_cnt = tx_cnt + 1;
            if (tx_cnt == BYTE_T) begin
                tx_done = 1'b1;
                tx_cnt  = 0;
            end
        end else begin
            tx_cnt = 0;
        end
    end

    // Scoreboard entries: {channel, baud, data}.
    logic [13:0] sb [$];
    logic        prev_en = 1'b0;
    logic [7:0]  cur_data = 8'h00;
    logic [2:0]  cur_baud = 3'd0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_send_en && !prev_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_byte", 32'(tx_data), 32'hFFFF);
                end else begin
                    logic [13:0] e;
                    e = sb.pop_front();
                    chk("grant_ch", 32'(grant_id), 32'(e[13:11]));
                    chk("tx_data", 32'(tx_data), 32'(e[7:0]));
                    chk("baud_set", 32'(baud_set), 32'(e[10:8]));
                    chk("ready_onehot", 32'(req_ready), 32'(4'b0001 << grant_id));
                end
                cur_data = tx_data;
                cur_baud = baud_set;
            end else if (req_ready != '0) begin
                chk("ready_outside_grant", 32'(req_ready), 32'h0);
            end
            if (tx_send_en && tx_done) begin
                chk("data_stable", 32'(tx_data), 32'(cur_data));
                chk("baud_stable", 32'(baud_set), 32'(cur_baud));
            end
        end
        prev_en = tx_send_en;
    end

    task automatic load(input int ch, input logic [7:0] d, input logic last,
                        input logic [2:0] baud);
        ch_mem[ch][ch_wr[ch]] = {last, d};
        ch_wr[ch] = ch_wr[ch] + 1;
        sb.push_back({3'(ch), baud, d});
    endtask

    task automatic wait_send(input int ch);
        int n;
        n = 0;
        while (!(tx_send_en && grant_id == 3'(ch)) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("wait_send_timeout", 32'(ch), 32'hFFFF);
    endtask

    task automatic drain(input string tag);
        int n;
        logic pend;
        n = 0;
        pend = 1'b1;
        while (pend && n < 600) begin
            @(negedge clk);
            n++;
            pend = (sb.size() != 0) || busy;
            for (int i = 0; i < NUM_CH; i++) if (ch_rd[i] != ch_wr[i]) pend = 1'b1;
        end
        chk(tag, 32'(sb.size()), 32'h0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_send_en", 32'(tx_send_en), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_baud_set", 32'(baud_set), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        chk("rst_byte_count", 32'(byte_count), 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
    endtask

    int n;
    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals();

        // single byte at baud code 4, with end-of-byte timing
        baud_sel = 3'd4;
        load(0, 8'h55, 1'b1, 3'd4);
        wait_send(0);
        n = 0;
        while (!tx_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("single_done_seen", 32'(tx_done), 32'h1);
        chk("single_en_before_done", 32'(tx_send_en), 32'h1);
        @(posedge clk); #1;
        chk("single_en_after_done", 32'(tx_send_en), 32'h0);
        chk("single_count", 32'(byte_count), 32'h1);
        chk("single_busy_gap", 32'(busy), 32'h1);
        @(posedge clk); #1;
        chk("single_busy_gap2", 32'(busy), 32'h1);
        @(posedge clk); #1;
        chk("single_busy_low", 32'(busy), 32'h0);
        drain("single_drain");

        // round robin from reset: 0,1,2,3 then next round starts at ch0
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < NUM_CH; i++) load(i, 8'hA0 + 8'(i), 1'b1, 3'd4);
        drain("rr_drain");
        chk("rr_count", 32'(byte_count), 32'h4);
        load(3, 8'hB3, 1'b1, 3'd4);
        sb.pop_back();
        load(0, 8'hB0, 1'b1, 3'd4);
        sb.push_back({3'd3, 3'd4, 8'hB3});
        drain("rr2_drain");
        chk("rr2_count", 32'(byte_count), 32'h6);

        // packet lock: ch2 packet completes before ch0 and ch1
        load(2, 8'h10, 1'b0, 3'd4);
        load(2, 8'h11, 1'b0, 3'd4);
        load(2, 8'h12, 1'b1, 3'd4);
        wait_send(2);
        load(0, 8'h20, 1'b1, 3'd4);
        load(1, 8'h30, 1'b1, 3'd4);
        drain("lock_drain");
        chk("lock_count", 32'(byte_count), 32'd11);

        // baud change mid-byte takes effect only on the next grant
        baud_sel = 3'd0;
        load(1, 8'h44, 1'b1, 3'd0);
        wait_send(1);
        baud_sel = 3'd2;
        @(posedge clk); #1;
        chk("baud_hold", 32'(baud_set), 32'h0);
        load(2, 8'h45, 1'b1, 3'd2);
        drain("baud_drain");
        chk("baud_new", 32'(baud_set), 32'h2);
        chk("baud_count", 32'(byte_count), 32'd13);

        // asynchronous reset during SEND, pending ch1 goes first afterwards
        load(0, 8'h66, 1'b1, 3'd2);
        load(1, 8'h77, 1'b1, 3'd2);
        wait_send(0);
        @(posedge clk);
        @(posedge clk); #3;
        chk("pre_rst_en", 32'(tx_send_en), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk); rst_n = 1'b1;
        drain("rst_drain");
        chk("rst_count", 32'(byte_count), 32'h1);

`ifdef UART_ARB_TIMEOUT_EN
        // watchdog: ch2 never completes, ch3 goes next
        tx_model_en = 1'b0;
        load(2, 8'h88, 1'b1, 3'd2);
        load(3, 8'h99, 1'b1, 3'd2);
        wait_send(2);
        repeat (99) @(posedge clk);
        #1;
        chk("to_still_send", 32'(tx_send_en), 32'h1);
        chk("to_err_early", 32'(timeout_err), 32'h0);
        @(posedge clk); #1;
        chk("to_err", 32'(timeout_err), 32'h1);
        chk("to_send_en", 32'(tx_send_en), 32'h0);
        chk("to_count", 32'(byte_count), 32'h1);
        tx_model_en = 1'b1;
        drain("to_drain");
        chk("to_count_after", 32'(byte_count), 32'h2);
        chk("to_sticky", 32'(timeout_err), 32'h1);
`else
        chk("no_timeout_err", 32'(timeout_err), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART byte transmitter among NUM_CH requesters. It sits between client logic and the transmitter. It accepts bytes over per-channel valid/ready handshakes and drives the transmitter's level-held send enable, data and baud select. It uses the transmitter's end-of-byte pulse to pace transfers, and can lock the grant to one channel for a multi-byte packet.

## Interface
Parameters:
- NUM_CH, 4: number of requesting channels (2..8).
- GAP_CYCLES, 2: idle cycles with send enable low between bytes (1..255).
- TIMEOUT_CYCLES, 65535: watchdog limit in clk cycles; used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_CH  channel i has a byte on req_data.
- req_data  input  8*NUM_CH  byte for channel i at bits [8i+7:8i].
- req_last  input  NUM_CH  byte on channel i ends its packet.
- req_ready  output  NUM_CH  one-cycle accept pulse; the byte is consumed when valid and ready are both high.
- baud_sel  input  3  requested baud code (0=9600 … 4=115200).
- tx_send_en  output  1  level enable to transmitter; held high for the whole byte.
- tx_data  output  8  byte to transmitter; stable while tx_send_en is high.
- tx_done  input  1  transmitter end-of-byte pulse.
- baud_set  output  3  baud code to transmitter.
- busy  output  1  high in any state other than IDLE.
- grant_id  output  3  index of the channel currently or last granted.
- byte_count  output  16  total bytes completed; wraps at 65535→0.
- timeout_err  output  1  sticky watchdog error; tied 0 without the macro.

## Operation
- FSM states: IDLE, SEND, GAP.
- **IDLE, unlocked:** pick the first channel with req_valid, searching from rr_ptr upward modulo NUM_CH.
- **IDLE, locked:** consider only the locked channel. Other channels wait even if they are valid.
- **On a grant g in IDLE:**
  - Pulse req_ready[g] for that cycle.
  - Register req_data[g] into tx_data and baud_sel into baud_set.
  - Set grant_id=g and tx_send_en=1, then go to SEND.
  - Set lock = ~req_last[g].
  - Set rr_ptr=(g+1) mod NUM_CH only when req_last[g]=1.
- **SEND:** hold tx_send_en, tx_data and baud_set constant. On tx_done=1:
  - Clear tx_send_en.
  - Increment byte_count.
  - Load the gap counter with GAP_CYCLES and go to GAP.
- **GAP:** decrement the gap counter; at 1, go to IDLE.
- tx_done is ignored in IDLE and GAP.
- baud_set changes only on a grant. It never changes mid-byte.
- If req_valid drops before a grant, nothing is accepted for that channel. No byte is lost or duplicated.
- A locked channel that stops asserting valid holds the lock indefinitely. This starvation of other channels is intended: the client owns packet framing.

## Timing
- All outputs are registered.
- Reset values:
  - tx_send_en=0, tx_data=0, baud_set=0.
  - req_ready=0, busy=0, grant_id=0, byte_count=0, timeout_err=0.
  - State IDLE, rr_ptr=0, lock=0.
- Grant latency:
  - req_valid seen in IDLE at edge N gives req_ready high during cycle N.
  - tx_send_en and tx_data are valid from edge N+1.
- End of byte:
  - tx_done high at edge M gives tx_send_en low and byte_count+1 from edge M+1.
  - The next grant is possible at the earliest GAP_CYCLES cycles after M+1.
- Minimum spacing between accepted bytes: 1 + byte time + 1 + GAP_CYCLES cycles.
- Simultaneous valid on several channels: exactly one req_ready bit is high per cycle.
- Reset mid-byte drops tx_send_en immediately (asynchronous). The in-flight byte is not counted.

## Configuration
- UART_ARB_TIMEOUT_EN defined:
  - A counter runs in SEND and clears on entry to SEND.
  - If it reaches TIMEOUT_CYCLES before tx_done, set timeout_err=1 (sticky until reset), clear tx_send_en and lock, advance rr_ptr past grant_id, and go to GAP.
  - byte_count is not incremented on a timeout.
- Macro undefined: no watchdog logic, and timeout_err is constant 0. SEND waits for tx_done indefinitely.

## Test plan
- Single byte, baud_sel=4: ch0 valid data 0x55 last=1 → req_ready[0] one cycle, tx_send_en high with tx_data=0x55 and baud_set=4 until tx_done, byte_count=1, busy low 2 cycles after the pulse.
- All four channels valid with last=1, bytes 0xA0..0xA3 → grants in order 0,1,2,3; next round starts at ch0; byte_count=4.
- Packet lock: ch2 sends 3 bytes 0x10,0x11,0x12 (last on the third) while ch0 and ch1 are valid → all of ch2 is sent first, then ch0.
- baud_sel changes from 0 to 2 mid-byte → baud_set stays 0 until the next grant, then becomes 2.
- Reset asserted in SEND → tx_send_en=0 and all outputs at reset values in the same cycle; after release, a pending ch1 is granted first.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, tx_done never asserted → timeout_err=1 at cycle 100 of SEND, tx_send_en=0, byte_count unchanged, next channel granted after the gap.
